// File: rtl/vga_pkg.sv
// Shared VGA constants: standard timing sets, colour constants, test-mode encodings
// and the tag record that travels down the alignment delay line.
package vga_pkg;

    // 1280x1024 @ 60 Hz
    localparam int SXGA_H_DISP  = 1280;
    localparam int SXGA_H_FRONT = 48;
    localparam int SXGA_H_SYNC  = 112;
    localparam int SXGA_H_BACK  = 248;
    localparam int SXGA_V_DISP  = 1024;
    localparam int SXGA_V_FRONT = 1;
    localparam int SXGA_V_SYNC  = 3;
    localparam int SXGA_V_BACK  = 38;

    // 640x480 @ 60 Hz
    localparam int VGA_H_DISP  = 640;
    localparam int VGA_H_FRONT = 16;
    localparam int VGA_H_SYNC  = 96;
    localparam int VGA_H_BACK  = 48;
    localparam int VGA_V_DISP  = 480;
    localparam int VGA_V_FRONT = 10;
    localparam int VGA_V_SYNC  = 2;
    localparam int VGA_V_BACK  = 33;

    localparam logic [11:0] COL_WHITE   = 12'hFFF;
    localparam logic [11:0] COL_RED     = 12'hF00;
    localparam logic [11:0] COL_MAGENTA = 12'hF0F;
    localparam logic [11:0] COL_YELLOW  = 12'hFF0;
    localparam logic [11:0] COL_GREEN   = 12'h0F0;
    localparam logic [11:0] COL_BLUE    = 12'h00F;
    localparam logic [11:0] COL_CYAN    = 12'h0FF;
    localparam logic [11:0] COL_BLACK   = 12'h000;
    localparam logic [11:0] COL_GREY    = 12'h888;

    typedef enum logic [1:0] {
        MODE_EXT   = 2'd0,
        MODE_BARS  = 2'd1,
        MODE_GRID  = 2'd2,
        MODE_SOLID = 2'd3
    } test_mode_e;

    typedef struct packed {
        logic        de;
        logic        hs;
        logic        vs;
        logic        fs;
        logic        ls;
        logic        ext;
        logic [11:0] col;
    } pix_tag_t;

    function automatic logic [11:0] bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    return COL_WHITE;
            3'd1:    return COL_RED;
            3'd2:    return COL_MAGENTA;
            3'd3:    return COL_YELLOW;
            3'd4:    return COL_GREEN;
            3'd5:    return COL_BLUE;
            3'd6:    return COL_CYAN;
            default: return COL_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/vga_pattern_gen.sv
// Built-in test pattern source. Bar index comes from a sub-counter that follows x,
// so no divider is needed for x / (H_DISP/8).
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int H_DISP = SXGA_H_DISP,
    parameter int CNT_W  = 11
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [CNT_W-1:0] x,
    input  logic [4:0]       y,
    input  logic             valid,
    input  test_mode_e       mode,
    output logic [11:0]      colour
);

    localparam logic [CNT_W-1:0] BW_M1 = CNT_W'(H_DISP / 8 - 1);

    logic [CNT_W-1:0] bar_cnt, cur_cnt;
    logic [2:0]       bar_idx, cur_idx;

    // x == 0 restarts the bar walk, which also covers line wrap and reset release
    always_comb begin
        cur_cnt = bar_cnt;
        cur_idx = bar_idx;
        if (x == '0) begin
            cur_cnt = '0;
            cur_idx = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            bar_cnt <= '0;
            bar_idx <= '0;
        end else if (cur_cnt == BW_M1) begin
            bar_cnt <= '0;
            bar_idx <= (cur_idx == 3'd7) ? 3'd7 : cur_idx + 3'd1;
        end else begin
            bar_cnt <= cur_cnt + CNT_W'(1);
            bar_idx <= cur_idx;
        end
    end

    always_comb begin
        colour = COL_BLACK;
        if (valid) begin
            case (mode)
                MODE_BARS:  colour = bar_colour(cur_idx);
                MODE_GRID:  colour = ((x[4:0] == 5'd0) || (y == 5'd0)) ? COL_WHITE : COL_BLACK;
                MODE_SOLID: colour = COL_GREY;
                default:    colour = COL_BLACK;
            endcase
        end
    end

endmodule

// File: rtl/vga_timing_pipe.sv
// VGA timing generator: issues pixel requests, aligns sync/DE/pattern to the
// PIX_LAT source latency, and registers the final output pixel.
module vga_timing_pipe
    import vga_pkg::*;
#(
    parameter int   H_DISP  = SXGA_H_DISP,
    parameter int   H_FRONT = SXGA_H_FRONT,
    parameter int   H_SYNC  = SXGA_H_SYNC,
    parameter int   H_BACK  = SXGA_H_BACK,
    parameter int   V_DISP  = SXGA_V_DISP,
    parameter int   V_FRONT = SXGA_V_FRONT,
    parameter int   V_SYNC  = SXGA_V_SYNC,
    parameter int   V_BACK  = SXGA_V_BACK,
    parameter logic H_POL   = 1'b1,
    parameter logic V_POL   = 1'b1,
    parameter int   PIX_LAT = 1,
    parameter int   CNT_W   = 11
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [1:0]       TEST_MODE,
    input  logic [11:0]      RGB,
    output logic [CNT_W-1:0] REQ_X,
    output logic [CNT_W-1:0] REQ_Y,
    output logic             REQ_VALID,
    output logic             VGA_HSYNC,
    output logic             VGA_VSYNC,
    output logic             VGA_DE,
    output logic [3:0]       VGA_RED,
    output logic [3:0]       VGA_GREEN,
    output logic [3:0]       VGA_BLUE,
    output logic             FRAME_START,
    output logic             LINE_START
);

    localparam int H_TOTAL = H_DISP + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISP + V_FRONT + V_SYNC + V_BACK;

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_DISP);
    localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_DISP);
    localparam logic [CNT_W-1:0] H_SS   = CNT_W'(H_DISP + H_FRONT);
    localparam logic [CNT_W-1:0] H_SE   = CNT_W'(H_DISP + H_FRONT + H_SYNC);
    localparam logic [CNT_W-1:0] V_SS   = CNT_W'(V_DISP + V_FRONT);
    localparam logic [CNT_W-1:0] V_SE   = CNT_W'(V_DISP + V_FRONT + V_SYNC);

    logic [CNT_W-1:0] hcnt, vcnt;
    logic             frame0;
    test_mode_e       mode_q, mode_eff;
    logic [11:0]      pat_col, pix_col;
    pix_tag_t         tag_req, tag_out;

    always_ff @(posedge CLK) begin
        if (RST) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (hcnt == H_LAST) begin
            hcnt <= '0;
            vcnt <= (vcnt == V_LAST) ? '0 : vcnt + CNT_W'(1);
        end else begin
            hcnt <= hcnt + CNT_W'(1);
        end
    end

    assign REQ_X     = hcnt;
    assign REQ_Y     = vcnt;
    assign REQ_VALID = (hcnt < H_ACT) && (vcnt < V_ACT);
    assign frame0    = (hcnt == '0) && (vcnt == '0);

    // The frame's first pixel already uses the freshly sampled mode, so a whole
    // frame is rendered in one mode and a change never tears mid-frame.
    assign mode_eff = frame0 ? test_mode_e'(TEST_MODE) : mode_q;

    always_ff @(posedge CLK) begin
        if (RST)         mode_q <= MODE_EXT;
        else if (frame0) mode_q <= test_mode_e'(TEST_MODE);
    end

    vga_pattern_gen #(
        .H_DISP (H_DISP),
        .CNT_W  (CNT_W)
    ) u_pat (
        .CLK    (CLK),
        .RST    (RST),
        .x      (hcnt),
        .y      (vcnt[4:0]),
        .valid  (REQ_VALID),
        .mode   (mode_eff),
        .colour (pat_col)
    );

    always_comb begin
        tag_req     = '0;
        tag_req.de  = REQ_VALID;
        tag_req.hs  = (hcnt >= H_SS) && (hcnt < H_SE);
        tag_req.vs  = (vcnt >= V_SS) && (vcnt < V_SE);
        tag_req.fs  = frame0;
        tag_req.ls  = (hcnt == '0) && (vcnt < V_ACT);
        tag_req.ext = (mode_eff == MODE_EXT);
        tag_req.col = pat_col;
    end

    generate
        if (PIX_LAT > 0) begin : g_dly
            pix_tag_t tag_pipe [PIX_LAT];
            always_ff @(posedge CLK) begin
                if (RST) begin
                    for (int k = 0; k < PIX_LAT; k++) tag_pipe[k] <= '0;
                end else begin
                    tag_pipe[0] <= tag_req;
                    for (int k = 1; k < PIX_LAT; k++) tag_pipe[k] <= tag_pipe[k-1];
                end
            end
            assign tag_out = tag_pipe[PIX_LAT-1];
        end else begin : g_nodly
            assign tag_out = tag_req;
        end
    endgenerate

    always_comb begin
        pix_col = '0;
        if (tag_out.de) pix_col = tag_out.ext ? RGB : tag_out.col;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            VGA_HSYNC   <= ~H_POL;
            VGA_VSYNC   <= ~V_POL;
            VGA_DE      <= 1'b0;
            VGA_RED     <= '0;
            VGA_GREEN   <= '0;
            VGA_BLUE    <= '0;
            FRAME_START <= 1'b0;
            LINE_START  <= 1'b0;
        end else begin
            VGA_HSYNC   <= tag_out.hs ? H_POL : ~H_POL;
            VGA_VSYNC   <= tag_out.vs ? V_POL : ~V_POL;
            VGA_DE      <= tag_out.de;
            VGA_RED     <= pix_col[11:8];
            VGA_GREEN   <= pix_col[7:4];
            VGA_BLUE    <= pix_col[3:0];
            FRAME_START <= tag_out.fs;
            LINE_START  <= tag_out.ls;
        end
    end

endmodule

// File: tb/tb_vga_timing_pipe.sv
// Scoreboard bench: a frame-position model predicts each output pixel and a
// monitor compares it when it emerges; a second instance covers low-active syncs.
module tb_vga_timing_pipe;

    localparam int HD = 16, HF = 2, HS = 3, HB = 3;
    localparam int VD = 8,  VF = 1, VS = 2, VB = 1;
    localparam int HT = HD + HF + HS + HB;
    localparam int VT = VD + VF + VS + VB;
    localparam int FT = HT * VT;
    localparam int LAT = 2;
    localparam int CW = 11;
    localparam int NCYC = 3 + FT * 12;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic [1:0]    TEST_MODE = 2'd0;
    logic [11:0]   RGB = 12'h000;

    logic [CW-1:0] REQ_X, REQ_Y, n_req_x, n_req_y;
    logic          REQ_VALID, VGA_HSYNC, VGA_VSYNC, VGA_DE, FRAME_START, LINE_START;
    logic [3:0]    VGA_RED, VGA_GREEN, VGA_BLUE;
    logic          n_req_valid, n_hsync, n_vsync, n_de, n_fs, n_ls;
    logic [3:0]    n_red, n_green, n_blue;

    vga_timing_pipe #(
        .H_DISP(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISP(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .H_POL(1'b1), .V_POL(1'b1), .PIX_LAT(LAT), .CNT_W(CW)
    ) dut (
        .CLK(CLK), .RST(RST), .TEST_MODE(TEST_MODE), .RGB(RGB),
        .REQ_X(REQ_X), .REQ_Y(REQ_Y), .REQ_VALID(REQ_VALID),
        .VGA_HSYNC(VGA_HSYNC), .VGA_VSYNC(VGA_VSYNC), .VGA_DE(VGA_DE),
        .VGA_RED(VGA_RED), .VGA_GREEN(VGA_GREEN), .VGA_BLUE(VGA_BLUE),
        .FRAME_START(FRAME_START), .LINE_START(LINE_START)
    );

    vga_timing_pipe #(
        .H_DISP(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISP(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .H_POL(1'b0), .V_POL(1'b0), .PIX_LAT(LAT), .CNT_W(CW)
    ) dut_n (
        .CLK(CLK), .RST(RST), .TEST_MODE(TEST_MODE), .RGB(RGB),
        .REQ_X(n_req_x), .REQ_Y(n_req_y), .REQ_VALID(n_req_valid),
        .VGA_HSYNC(n_hsync), .VGA_VSYNC(n_vsync), .VGA_DE(n_de),
        .VGA_RED(n_red), .VGA_GREEN(n_green), .VGA_BLUE(n_blue),
        .FRAME_START(n_fs), .LINE_START(n_ls)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int          tgt;
        bit          de, hs, vs, fs, ls;
        logic [11:0] col;
    } exp_t;

    exp_t        q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [11:0] rgb_by_cyc [0:NCYC-1];
    logic [11:0] BARS [8] = '{12'hFFF, 12'hF00, 12'hF0F, 12'hFF0, 12'h0F0, 12'h00F, 12'h0FF, 12'h000};

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, got, want);
        end
    endtask

    function automatic logic [11:0] ref_colour(input int x, input int y, input int mode,
                                               input logic [11:0] rgb);
        int bar;
        if (x >= HD || y >= VD) return 12'h000;
        case (mode)
            0: return rgb;
            1: begin
                bar = x / (HD / 8);
                if (bar > 7) bar = 7;
                return BARS[bar];
            end
            2: return ((x % 32 == 0) || (y % 32 == 0)) ? 12'hFFF : 12'h000;
            default: return 12'h888;
        endcase
    endfunction

    // Stimulus + expectation producer
    initial begin
        int   pos, frame_no, frame_mode, rst_at, x, y, c;
        bit   prev_rst, rst_now;
        exp_t e;
        pos = 0; frame_no = -1; frame_mode = 0; prev_rst = 1'b1;
        rst_at = 3 + FT * 7 + HT * 3 + int'($urandom_range(2, HT - 3));
        for (int k = 0; k < NCYC; k++) begin
            @(posedge CLK);
            #1;
            c = cyc;
            pos = prev_rst ? 0 : (pos + 1) % FT;
            x = pos % HT;
            y = pos / HT;
            chk("req_x", 32'(REQ_X), 32'(x));
            chk("req_y", 32'(REQ_Y), 32'(y));
            chk("req_valid", 32'(REQ_VALID), 32'(x < HD && y < VD));
            rst_now = (k < 3) || (k == rst_at);
            RST = rst_now;
            if (pos == 0 && !rst_now) frame_no++;
            if (pos == 100 && frame_no < 4)
                TEST_MODE = 2'((frame_no + 1) % 4);
            else if (pos == 100 || (frame_no >= 4 && $urandom_range(0, 499) == 0))
                TEST_MODE = 2'($urandom_range(0, 3));
            rgb_by_cyc[k] = (frame_no < 5) ? {4'(y), 4'(x), 4'h5} : 12'($urandom);
            RGB = (k >= LAT) ? rgb_by_cyc[k - LAT] : 12'h000;
            if (rst_now) begin
                while (q.size() > 0 && q[$].tgt > c) void'(q.pop_back());
                for (int d = 1; d <= LAT + 1; d++) begin
                    e.tgt = c + d; e.de = 0; e.hs = 0; e.vs = 0; e.fs = 0; e.ls = 0; e.col = 12'h000;
                    q.push_back(e);
                end
            end else begin
                if (pos == 0) frame_mode = int'(TEST_MODE);
                e.tgt = c + LAT + 1;
                e.de  = (x < HD) && (y < VD);
                e.hs  = (x >= HD + HF) && (x < HD + HF + HS);
                e.vs  = (y >= VD + VF) && (y < VD + VF + VS);
                e.fs  = (pos == 0);
                e.ls  = (x == 0) && (y < VD);
                e.col = ref_colour(x, y, frame_mode, rgb_by_cyc[k]);
                q.push_back(e);
            end
            prev_rst = rst_now;
        end
        RST = 1'b0;
        repeat (LAT + 3) @(posedge CLK);
        #1;
        chk("drain", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Monitor: every cycle is an output cycle; compare the entry due now
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            while (q.size() > 0 && q[0].tgt < cyc) begin
                chk("stale_entry", 32'(q[0].tgt), 32'(cyc));
                void'(q.pop_front());
            end
            if (q.size() > 0 && q[0].tgt == cyc) begin
                e = q.pop_front();
                chk("de", 32'(VGA_DE), 32'(e.de));
                chk("hsync", 32'(VGA_HSYNC), 32'(e.hs));
                chk("vsync", 32'(VGA_VSYNC), 32'(e.vs));
                chk("frame_start", 32'(FRAME_START), 32'(e.fs));
                chk("line_start", 32'(LINE_START), 32'(e.ls));
                chk("colour", 32'({VGA_RED, VGA_GREEN, VGA_BLUE}), 32'(e.col));
                chk("hsync_lowpol", 32'(n_hsync), 32'(!e.hs));
                chk("vsync_lowpol", 32'(n_vsync), 32'(!e.vs));
                chk("de_lowpol", 32'(n_de), 32'(e.de));
                chk("colour_lowpol", 32'({n_red, n_green, n_blue}), 32'(e.col));
            end
        end
    end

endmodule

// File: doc/vga_timing_pipe.md
Name: vga_timing_pipe

Overview:
- Parametrised VGA timing generator and pixel output stage.
- Runs on an externally supplied pixel clock; clock generation lives outside this block.
- Issues pixel-coordinate requests to an upstream frame source and accepts RGB back after a fixed, parametrised latency.
- Aligns sync and blanking to that latency, and adds built-in test patterns selected per frame.

Parameters:
- H_DISP, 1280, active pixels per line
- H_FRONT, 48, horizontal front porch (pixels)
- H_SYNC, 112, horizontal sync width (pixels)
- H_BACK, 248, horizontal back porch (pixels)
- V_DISP, 1024, active lines per frame
- V_FRONT, 1, vertical front porch (lines)
- V_SYNC, 3, vertical sync width (lines)
- V_BACK, 38, vertical back porch (lines)
- H_POL, 1, HSYNC active level
- V_POL, 1, VSYNC active level
- PIX_LAT, 1, cycles from request to valid RGB input; legal range 0..4
- CNT_W, 11, counter and coordinate width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- CLK  in  1  pixel clock
- RST  in  1  synchronous reset, active high
- TEST_MODE  in  2  0=external RGB, 1=colour bars, 2=grid, 3=solid grey
- RGB  in  12  {R[3:0],G[3:0],B[3:0]}, valid PIX_LAT cycles after the matching request
- REQ_X  out  CNT_W  requested pixel column
- REQ_Y  out  CNT_W  requested pixel line
- REQ_VALID  out  1  request lies in the active area
- VGA_HSYNC  out  1  horizontal sync
- VGA_VSYNC  out  1  vertical sync
- VGA_DE  out  1  active-video flag aligned to the colour outputs
- VGA_RED  out  4  red output
- VGA_GREEN  out  4  green output
- VGA_BLUE  out  4  blue output
- FRAME_START  out  1  one-cycle pulse aligned with output pixel (0,0)
- LINE_START  out  1  one-cycle pulse aligned with output pixel (0,y) of every active line

Behaviour:
- Derived totals: H_TOTAL = sum of the four H parameters; V_TOTAL = sum of the four V parameters.
- Horizontal counter hcnt: counts 0..H_TOTAL-1, then wraps to 0.
- Vertical counter vcnt: increments only when hcnt == H_TOTAL-1, counts 0..V_TOTAL-1, then wraps to 0.
- Request stage (cycle t), combinational from the counters:
  - REQ_X = hcnt, REQ_Y = vcnt.
  - REQ_VALID = (hcnt < H_DISP) && (vcnt < V_DISP).
- Raw sync terms at stage t:
  - HSYNC is active while H_DISP+H_FRONT <= hcnt < H_DISP+H_FRONT+H_SYNC.
  - VSYNC uses the same rule on vcnt with the V parameters.
- Alignment pipeline: DE, sync terms, start pulses and the pattern colour pass through a PIX_LAT-deep delay line.
- Output register: samples the delayed terms together with RGB. Pixel requested at cycle t appears on the outputs during cycle t+PIX_LAT+1 (fixed latency PIX_LAT+1).
- Colour select:
  - Mode 0 outputs RGB.
  - Modes 1–3 ignore RGB and output the pattern.
  - Colour outputs are forced to 0 whenever the delayed DE = 0.
- Colour bars: bar width BW = H_DISP/8. Bar index = min(x/BW, 7), produced by a bar sub-counter (no divider). Bar colours in order: FFF, F00, F0F, FF0, 0F0, 00F, 0FF, 000.
- Grid: FFF when x[4:0]==0 or y[4:0]==0, otherwise 000.
- Solid: 888.
- TEST_MODE capture: sampled into an internal register only when hcnt==0 && vcnt==0 and at reset. Mid-frame changes take effect at the next frame, so no tearing.
- Sync polarity: output sync = raw_active ? POL : ~POL.
- Reset, on any RST cycle including mid-frame:
  - hcnt = vcnt = 0; mode register = 0; delay line cleared.
  - VGA_HSYNC = ~H_POL, VGA_VSYNC = ~V_POL.
  - VGA_DE, colour outputs, FRAME_START, LINE_START = 0.
  - Request outputs reflect counters (0,0) with REQ_VALID = 1.
  - First output pixel (0,0) appears PIX_LAT+1 cycles after RST deasserts.
- PIX_LAT = 0: the delay line is empty and RGB is sampled in the same cycle as its request.

Decomposition:
- Package vga_pkg:
  - Timing constant sets for 1280x1024@60 and 640x480@60.
  - 12-bit colour constants.
  - TEST_MODE encodings.
- Sub-module vga_pattern_gen: takes x, y, valid and mode; produces a 12-bit colour. Holds the bar sub-counter.

Test Plan:
- Small timing (H 16/2/3/3 → H_TOTAL 24; V 8/1/2/1 → V_TOTAL 12), PIX_LAT=2, mode 0, RGB = {REQ_Y[3:0], REQ_X[3:0], 4'h5} delayed 2 cycles.
  - Output pixel (x,y) equals {y,x,5}.
  - VGA_DE is high exactly 16 of every 24 cycles on lines 0..7.
- Same configuration: HSYNC active for hcnt 18..20 (delayed 3 cycles at the output); VSYNC active for lines 9..10; line period 24 cycles; frame period 288 cycles.
- H_POL = 0, V_POL = 0: syncs idle high and pulse low with the same widths; reset values are 1.
- Mode 1 at H_DISP = 16:
  - Pixels 0–1 = FFF, 2–3 = F00, …, 14–15 = 000.
  - Blanking = 000.
  - TEST_MODE changed mid-frame switches only at the next FRAME_START.
- Mode 2: colour FFF at x=0 and on line y=0, 000 elsewhere; mode 3: colour 888 across the whole active area.
- Assert RST for 1 cycle mid-line:
  - Outputs return to reset values on the next edge.
  - FRAME_START fires PIX_LAT+1 cycles after release.
  - No stale pipeline pixel is emitted.
